gate_vector_gen: RTL and testbench

//  Self-checking stimulus stage directly upstream of a 2-input basic gate (A_i/B_i -> F_o).
//  On start, drives all four input vectors onto A_o/B_o, holds each for HOLD_CYCLES clocks,

---
 rtl/gate_gen_pkg.sv | 19 +
 rtl/gate_ref_model.sv | 22 ++
 rtl/gate_vector_gen.sv | 146 ++++++++++++++
 tb/tb_gate_vector_gen.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/gate_gen_pkg.sv
// Shared definitions for the gate vector generator: gate opcodes, FSM states, vector count.
package gate_gen_pkg;

  localparam int unsigned NUM_VEC = 4;

  typedef enum logic [1:0] {
    OP_AND  = 2'd0,
    OP_OR   = 2'd1,
    OP_XOR  = 2'd2,
    OP_NAND = 2'd3
  } gate_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/gate_ref_model.sv
// Combinational golden model of a 2-input basic gate selected by opcode.
module gate_ref_model
  import gate_gen_pkg::*;
(
  input  logic [1:0] op_i,
  input  logic       a_i,
  input  logic       b_i,
  output logic       expected_o
);

  always_comb begin
    expected_o = 1'b0;
    case (gate_op_e'(op_i))
      OP_AND:  expected_o = a_i & b_i;
      OP_OR:   expected_o = a_i | b_i;
      OP_XOR:  expected_o = a_i ^ b_i;
      OP_NAND: expected_o = ~(a_i & b_i);
      default: expected_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/gate_vector_gen.sv
// Sweeps {B,A} = 00..11 into a 2-input gate, checks F against gate_ref_model, reports pass/fail.
// Optional first-failure capture enabled by defining GATE_VECTOR_GEN_FIRST_FAIL_EN.
module gate_vector_gen
  import gate_gen_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 5,
  parameter int unsigned GATE_OP     = 1,
  parameter int unsigned ERR_W       = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  output logic             A_o,
  output logic             B_o,
  input  logic             F_i,
  output logic [1:0]       vec_idx_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             pass_o,
`ifdef GATE_VECTOR_GEN_FIRST_FAIL_EN
  output logic             first_fail_vld_o,
  output logic [1:0]       first_fail_idx_o,
`endif
  output logic [ERR_W-1:0] err_cnt_o
);

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);
  localparam logic [1:0] OP        = 2'(GATE_OP);
  localparam logic [1:0] LAST_VEC  = 2'(NUM_VEC - 1);

  state_e           state_q, state_d;
  logic [7:0]       hold_q, hold_d;
  logic [1:0]       idx_q, idx_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic             exp_bit;
  logic             start_acc;
  logic             sample;
  logic             mismatch;

  gate_ref_model u_ref (
    .op_i       (OP),
    .a_i        (idx_q[0]),
    .b_i        (idx_q[1]),
    .expected_o (exp_bit)
  );

  assign start_acc = (state_q != ST_DRIVE) && start_i;
  assign sample    = (state_q == ST_DRIVE) && (hold_q == HOLD_LAST);
  assign mismatch  = sample && (F_i != exp_bit);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      hold_q  <= '0;
      idx_q   <= '0;
      err_q   <= '0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    idx_d   = idx_q;
    err_d   = err_q;
    done_d  = done_q;
    pass_d  = pass_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_acc) begin
          state_d = ST_DRIVE;
          hold_d  = '0;
          idx_d   = '0;
          err_d   = '0;
          done_d  = 1'b0;
          pass_d  = 1'b0;
        end
      end
      ST_DRIVE: begin
        hold_d = hold_q + 8'd1;
        if (mismatch && (err_q != '1)) err_d = err_q + ERR_W'(1);
        if (sample) begin
          hold_d = '0;
          if (idx_q == LAST_VEC) begin
            // pass uses err_d so a miss on the final vector is reflected on DONE entry
            state_d = ST_DONE;
            done_d  = 1'b1;
            pass_d  = (err_d == '0);
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef GATE_VECTOR_GEN_FIRST_FAIL_EN
  logic       ffv_q, ffv_d;
  logic [1:0] ffi_q, ffi_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ffv_q <= 1'b0;
      ffi_q <= '0;
    end else begin
      ffv_q <= ffv_d;
      ffi_q <= ffi_d;
    end
  end

  always_comb begin
    ffv_d = ffv_q;
    ffi_d = ffi_q;
    if (start_acc) begin
      ffv_d = 1'b0;
      ffi_d = '0;
    end else if (mismatch && !ffv_q) begin
      ffv_d = 1'b1;
      ffi_d = idx_q;
    end
  end

  assign first_fail_vld_o = ffv_q;
  assign first_fail_idx_o = ffi_q;
`endif

  assign A_o       = idx_q[0];
  assign B_o       = idx_q[1];
  assign vec_idx_o = idx_q;
  assign busy_o    = (state_q == ST_DRIVE);
  assign done_o    = done_q;
  assign pass_o    = pass_q;
  assign err_cnt_o = err_q;

endmodule

// File: tb/tb_gate_vector_gen.sv
// Bench: two generators (HOLD=5/ERR_W=3 and HOLD=1/ERR_W=1, both expecting OR) driving a
// gate whose truth table tt is chosen by the bench; a sweep-time model predicts every output.
module tb_gate_vector_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [3:0] tt = 4'b1110;

  logic       a0, b0, f0, busy0, done0, pass0;
  logic [1:0] idx0;
  logic [2:0] err0;
  logic       a1, b1, f1, busy1, done1, pass1;
  logic [1:0] idx1;
  logic [0:0] err1;
`ifdef GATE_VECTOR_GEN_FIRST_FAIL_EN
  logic       ffv0, ffv1;
  logic [1:0] ffi0, ffi1;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // Gate under test: F = tt[{B,A}]
  assign f0 = tt[{b0, a0}];
  assign f1 = tt[{b1, a1}];

  gate_vector_gen #(.HOLD_CYCLES(5), .GATE_OP(1), .ERR_W(3)) u0 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .A_o(a0), .B_o(b0), .F_i(f0),
    .vec_idx_o(idx0), .busy_o(busy0), .done_o(done0), .pass_o(pass0),
`ifdef GATE_VECTOR_GEN_FIRST_FAIL_EN
    .first_fail_vld_o(ffv0), .first_fail_idx_o(ffi0),
`endif
    .err_cnt_o(err0)
  );

  gate_vector_gen #(.HOLD_CYCLES(1), .GATE_OP(1), .ERR_W(1)) u1 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .A_o(a1), .B_o(b1), .F_i(f1),
    .vec_idx_o(idx1), .busy_o(busy1), .done_o(done1), .pass_o(pass1),
`ifdef GATE_VECTOR_GEN_FIRST_FAIL_EN
    .first_fail_vld_o(ffv1), .first_fail_idx_o(ffi1),
`endif
    .err_cnt_o(err1)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: mode 0=idle 1=sweeping 2=done; k = edges since accepted start.
  int H[2]    = '{5, 1};
  int EMAX[2] = '{7, 1};
  int m_mode[2] = '{0, 0};
  int m_k[2]    = '{0, 0};
  int m_err[2]  = '{0, 0};
  int m_ffv[2]  = '{0, 0};
  int m_ffi[2]  = '{0, 0};

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_mode[i] = 0; m_k[i] = 0; m_err[i] = 0; m_ffv[i] = 0; m_ffi[i] = 0;
      end else if (m_mode[i] != 1 && start) begin
        m_mode[i] = 1; m_k[i] = 0; m_err[i] = 0; m_ffv[i] = 0; m_ffi[i] = 0;
      end else if (m_mode[i] == 1) begin
        m_k[i]++;
        if (m_k[i] % H[i] == 0) begin
          int v;
          v = m_k[i] / H[i] - 1;
          if (int'(tt[v]) != int'(v != 0)) begin
            if (m_err[i] < EMAX[i]) m_err[i]++;
            if (m_ffv[i] == 0) begin m_ffv[i] = 1; m_ffi[i] = v; end
          end
          if (v == 3) m_mode[i] = 2;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        int e_idx, a_idx, a_a, a_b, a_busy, a_done, a_pass, a_err;
        e_idx = (m_mode[i] == 1) ? m_k[i] / H[i] : (m_mode[i] == 2 ? 3 : 0);
        a_idx  = (i == 0) ? int'(idx0)  : int'(idx1);
        a_a    = (i == 0) ? int'(a0)    : int'(a1);
        a_b    = (i == 0) ? int'(b0)    : int'(b1);
        a_busy = (i == 0) ? int'(busy0) : int'(busy1);
        a_done = (i == 0) ? int'(done0) : int'(done1);
        a_pass = (i == 0) ? int'(pass0) : int'(pass1);
        a_err  = (i == 0) ? int'(err0)  : int'(err1);
        chk($sformatf("u%0d_idx", i), a_idx, e_idx);
        chk($sformatf("u%0d_A", i), a_a, e_idx % 2);
        chk($sformatf("u%0d_B", i), a_b, e_idx / 2);
        chk($sformatf("u%0d_busy", i), a_busy, int'(m_mode[i] == 1));
        chk($sformatf("u%0d_done", i), a_done, int'(m_mode[i] == 2));
        chk($sformatf("u%0d_err", i), a_err, m_err[i]);
        if (m_mode[i] != 1)
          chk($sformatf("u%0d_pass", i), a_pass, int'(m_mode[i] == 2 && m_err[i] == 0));
`ifdef GATE_VECTOR_GEN_FIRST_FAIL_EN
        chk($sformatf("u%0d_ffv", i), (i == 0) ? int'(ffv0) : int'(ffv1), m_ffv[i]);
        if (m_ffv[i] != 0)
          chk($sformatf("u%0d_ffi", i), (i == 0) ? int'(ffi0) : int'(ffi1), m_ffi[i]);
`endif
      end
    end
  end

  task automatic check_zero(input string tag);
    chk({tag, "_idx0"}, int'(idx0), 0);
    chk({tag, "_A0B0"}, int'({b0, a0}), 0);
    chk({tag, "_busy0"}, int'(busy0), 0);
    chk({tag, "_done0"}, int'(done0), 0);
    chk({tag, "_pass0"}, int'(pass0), 0);
    chk({tag, "_err0"}, int'(err0), 0);
    chk({tag, "_done1"}, int'(done1), 0);
    chk({tag, "_err1"}, int'(err1), 0);
  endtask

  // Pulse start, optionally poke start at cycles 3 and 10, wait for u0 done.
  task automatic sweep(input bit pokes, output int lat0, output int lat1);
    int cyc;
    @(negedge clk); #1 start = 1'b1;
    @(negedge clk); #1 start = 1'b0;
    cyc = 0; lat0 = -1; lat1 = -1;
    while (lat0 < 0 && cyc < 40) begin
      if (done1 && lat1 < 0) lat1 = cyc;
      if (done0) lat0 = cyc;
      else begin
        @(negedge clk);
        cyc++;
        #1 start = pokes && (cyc == 3 || cyc == 10);
      end
    end
    start = 1'b0;
    if (lat0 < 0) chk("sweep_timeout", cyc, 20);
  endtask

  initial begin
    int l0, l1;
    repeat (2) @(negedge clk);
    check_zero("reset");
    #1 rst = 1'b0;

    // 1: correct OR gate
    tt = 4'b1110;
    sweep(1'b0, l0, l1);
    chk("t1_lat0", l0, 20);
    chk("t1_lat1", l1, 4);
    chk("t1_err0", int'(err0), 0);
    chk("t1_pass0", int'(pass0), 1);
    chk("t1_pass1", int'(pass1), 1);

    // 2: AND gate in place of OR
    tt = 4'b1000;
    sweep(1'b0, l0, l1);
    chk("t2_err0", int'(err0), 2);
    chk("t2_pass0", int'(pass0), 0);
    chk("t2_err1_sat", int'(err1), 1);
`ifdef GATE_VECTOR_GEN_FIRST_FAIL_EN
    chk("t2_ffi0", int'(ffi0), 1);
`endif

    // 3: F tied low
    tt = 4'b0000;
    sweep(1'b0, l0, l1);
    chk("t3_err0", int'(err0), 3);
    chk("t3_err1_sat", int'(err1), 1);
    chk("t3_pass1", int'(pass1), 0);

    // 4: starts while busy are ignored; start in DONE restarts
    tt = 4'b1110;
    sweep(1'b1, l0, l1);
    chk("t4_lat0", l0, 20);
    @(negedge clk); #1 start = 1'b1;
    @(negedge clk); #1 start = 1'b0;
    chk("t4_done_drop", int'(done0), 0);
    chk("t4_err_clr", int'(err0), 0);

    // 5: asynchronous reset mid-sweep
    repeat (11) @(negedge clk);
    #1 rst = 1'b1;
    #1 check_zero("t5");
    @(negedge clk); #1 rst = 1'b0;
    sweep(1'b0, l0, l1);
    chk("t5_restart_lat", l0, 20);

    // Random: gate table, start pulses and occasional reset
    for (int n = 0; n < 1500; n++) begin
      @(negedge clk);
      #1;
      if ($urandom_range(0, 19) == 0) tt = 4'($urandom);
      start = ($urandom_range(0, 9) == 0);
      rst   = ($urandom_range(0, 149) == 0);
    end
    @(negedge clk); #1 rst = 1'b0; start = 1'b0;
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
